muldiv_iter: RTL

Parametrised HI/LO multiply/divide unit for the EX stage of the pipelined MIPS core. Successor to the fixed 32-bit behavioural-delay unit: a real iterative restoring divider, a configurable-latency multiplier, signed/unsigned multiply-accumulate/subtract, defined divide-by-zero and overflow results, and a flush input for exception squash. The pipeline stalls any HI/LO-touching instruction while start or busy is high.

---
 rtl/muldiv_iter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// HI/LO multiply/divide unit for the EX stage: fixed-latency multiply and
// multiply-accumulate, iterative restoring divide, mthi/mtlo and flush.
module muldiv_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             start,
  output logic             accepted,
  output logic             div_zero
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MSUB  = 4'b1000;
  localparam logic [3:0] OP_MADDU = 4'b1001;
  localparam logic [3:0] OP_MSUBU = 4'b1010;

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opr_a, opr_b, dsr, quo, rem;
  logic [3:0]         opr_op;
  logic               op_is_div, opr_signed;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  // Apply signs to the magnitude quotient/remainder; b==0 yields the defined result.
  function automatic logic [2*WIDTH-1:0] div_fix(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                                                 input logic sgn);
    logic [WIDTH-1:0] qf, rf;
    if (y == '0) return {x, {WIDTH{1'b1}}};
    qf = (sgn && (x[WIDTH-1] ^ y[WIDTH-1])) ? -q : q;
    rf = (sgn && x[WIDTH-1]) ? -r : r;
    return {rf, qf};
  endfunction

  assign accepted  = (op >= OP_MULT) && (op <= OP_MSUBU) && !busy && !flush && !reset;
  assign start     = accepted && (op != OP_MTHI) && (op != OP_MTLO);
  assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);

  // Multiply: sign-extended operands give the signed product modulo 2^(2W)
  logic                      mul_signed;
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u, prod, mul_res;

  assign mul_signed = (opr_op == OP_MULT) || (opr_op == OP_MADD) || (opr_op == OP_MSUB);
  assign prod_s = $signed({{WIDTH{opr_a[WIDTH-1]}}, opr_a}) * $signed({{WIDTH{opr_b[WIDTH-1]}}, opr_b});
  assign prod_u = {{WIDTH{1'b0}}, opr_a} * {{WIDTH{1'b0}}, opr_b};
  assign prod   = mul_signed ? prod_s : prod_u;

  always_comb begin
    mul_res = prod;
    if ((opr_op == OP_MADD) || (opr_op == OP_MADDU)) mul_res = {hi, lo} + prod;
    else if ((opr_op == OP_MSUB) || (opr_op == OP_MSUBU)) mul_res = {hi, lo} - prod;
  end

  // Divide: one restoring step per cycle on magnitudes
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  assign opr_signed = (opr_op == OP_DIV);
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dsr};
  assign rem_nxt = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};

  always_ff @(posedge clk) begin
    if (start) begin
      opr_a  <= a;
      opr_b  <= b;
      opr_op <= op;
      quo    <= mag(a, op == OP_DIV);
      dsr    <= mag(b, op == OP_DIV);
      rem    <= '0;
    end else if (state == DIV && cnt != '0) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accepted) begin
            if (op == OP_MTHI) hi <= a;
            else if (op == OP_MTLO) lo <= a;
            else if (op_is_div) begin
              state <= DIV;
              busy  <= 1'b1;
              cnt   <= CNT_W'(WIDTH);
            end else begin
              state <= MUL;
              busy  <= 1'b1;
              cnt   <= CNT_W'(MUL_LAT - 1);
            end
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            {hi, lo} <= mul_res;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            {hi, lo} <= div_fix(opr_a, opr_b, quo, rem, opr_signed);
            div_zero <= (opr_b == '0);
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
